pipe_delay: RTL

PIPE_DELAY -- requirements
Module: pipe_delay

---
 rtl/pipe_delay.sv | 90 +++++++++
 1 files changed

// File: rtl/pipe_delay.sv
// Fixed-latency delay line with per-stage valid bits, stall, flush, a
// combinational stage tap and a registered occupancy count.

module pipe_delay_stage #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);
  // Flush only drops the valid bit; data is left in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RST_VAL;
      q_vld <= 1'b0;
    end else if (flush) begin
      q_vld <= 1'b0;
    end else if (en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end
endmodule

module pipe_delay #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             en,
  input  logic             flush,
  input  logic [5:0]       tap_sel,
  output logic [WIDTH-1:0] out_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] tap_o,
  output logic             tap_valid_o,
  output logic [6:0]       count_o
);
  // Index 0 is the input; index s+1 is the register of stage s.
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            vld_pipe;
  logic [6:0]                count_q;

  assign dat_pipe[0] = in;
  assign vld_pipe[0] = in_valid;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    pipe_delay_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .d     (dat_pipe[s]),
      .d_vld (vld_pipe[s]),
      .q     (dat_pipe[s+1]),
      .q_vld (vld_pipe[s+1])
    );
  end

  // Entering and leaving beats cancel when both are valid.
  always_ff @(posedge clk) begin
    if (rst || flush) count_q <= '0;
    else if (en)      count_q <= count_q + 7'(vld_pipe[0]) - 7'(vld_pipe[DEPTH]);
  end

  always_comb begin
    tap_o       = '0;
    tap_valid_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == 6'(i)) begin
        tap_o       = dat_pipe[i+1];
        tap_valid_o = vld_pipe[i+1];
      end
    end
  end

  assign out_o       = dat_pipe[DEPTH];
  assign out_valid_o = vld_pipe[DEPTH];
  assign count_o     = count_q;
endmodule
